// File: rtl/retinex_pkg.sv
// rtl/retinex_pkg.sv - shared widths, rounding constant and mantissa helper for the retinex antilog stage
package retinex_pkg;

    localparam int EXP_CODE_W     = 10;
    localparam int EXP_FRAC_W     = 6;
    localparam int EXP_INT_W      = 3;
    localparam int EXP_MANT_W     = 11;
    localparam int EXP_ACC_W      = 18;
    localparam int EXP_MANT_SHIFT = 10;
    localparam int EXP_ROM_DEPTH  = 64;
    localparam int EXP_RND        = 512;
    localparam int PIX_W          = 8;
    localparam int SAT_CNT_W      = 20;

    typedef struct packed {
        logic                 valid;
        logic [EXP_INT_W-1:0] ipart;
        logic                 sat;
        logic                 sof;
        logic                 eol;
    } exp_s1_t;

    // Elaboration-time table entry: round(1024 * 2^(f/64)).
    function automatic logic [EXP_MANT_W-1:0] exp_mant(input int f);
        real r;
        r = 1024.0 * (2.0 ** (real'(f) / 64.0));
        return EXP_MANT_W'($rtoi(r + 0.5));
    endfunction

endpackage

// File: rtl/retinex_exp_rom.sv
// rtl/retinex_exp_rom.sv - 64x11 synchronous mantissa ROM, read gated by the pipeline enable
module retinex_exp_rom
    import retinex_pkg::*;
(
    input  logic                  clk,
    input  logic                  en,
    input  logic [EXP_FRAC_W-1:0] addr,
    output logic [EXP_MANT_W-1:0] dout
);

    logic [EXP_MANT_W-1:0] rom [EXP_ROM_DEPTH];

    for (genvar g = 0; g < EXP_ROM_DEPTH; g++) begin : g_rom
        localparam logic [EXP_MANT_W-1:0] MANT = exp_mant(g);
        assign rom[g] = MANT;
    end

    always_ff @(posedge clk) begin
        if (en) begin
            dout <= rom[addr];
        end
    end

endmodule

// File: rtl/retinex_exp_lut.sv
// rtl/retinex_exp_lut.sv - 2-stage log2-code to linear pixel converter with saturation and sideband
// Optional per-frame saturation statistics: RETINEX_EXP_STAT_EN
module retinex_exp_lut
    import retinex_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [EXP_CODE_W-1:0] in_code,
    input  logic                  in_sof,
    input  logic                  in_eol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PIX_W-1:0]      out_data,
    output logic                  out_sat,
    output logic                  out_sof,
    output logic                  out_eol
`ifdef RETINEX_EXP_STAT_EN
    ,
    output logic [SAT_CNT_W-1:0]  sat_cnt_frame
`endif
);

    logic [1:0]            rst_sync;
    logic                  rstn_i;
    logic                  en;
    logic                  accept;
    logic                  code_sat;
    exp_s1_t               s1;
    logic [EXP_MANT_W-1:0] mant;
    logic [EXP_ACC_W-1:0]  scaled;
    logic [EXP_ACC_W-1:0]  rounded;
    logic [PIX_W-1:0]      pix_lin;
    logic [PIX_W-1:0]      pix_next;

    // Reset asserts immediately, releases two clocks later on a clean edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rstn_i   = rst_sync[1];
    assign en       = rstn_i & (~out_valid | out_ready);
    assign in_ready = en;
    assign accept   = in_valid & en;
    assign code_sat = in_code[EXP_CODE_W-1];

    retinex_exp_rom u_rom (
        .clk  (clk),
        .en   (en),
        .addr (in_code[EXP_FRAC_W-1:0]),
        .dout (mant)
    );

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            s1 <= '0;
        end else if (en) begin
            s1.valid <= in_valid;
            s1.ipart <= in_code[EXP_FRAC_W +: EXP_INT_W];
            s1.sat   <= code_sat;
            s1.sof   <= in_sof;
            s1.eol   <= in_eol;
        end
    end

    // Below 512 the shifted mantissa tops out at 2026<<7, so 18 bits never overflow.
    assign scaled   = EXP_ACC_W'(mant) << s1.ipart;
    assign rounded  = scaled + EXP_ACC_W'(EXP_RND);
    assign pix_lin  = PIX_W'(rounded >> EXP_MANT_SHIFT) - PIX_W'(1);
    assign pix_next = s1.sat ? {PIX_W{1'b1}} : pix_lin;

    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_sof   <= 1'b0;
            out_eol   <= 1'b0;
        end else if (en) begin
            out_valid <= s1.valid;
            out_data  <= s1.valid ? pix_next : '0;
            out_sat   <= s1.valid & s1.sat;
            out_sof   <= s1.valid & s1.sof;
            out_eol   <= s1.valid & s1.eol;
        end
    end

`ifdef RETINEX_EXP_STAT_EN
    logic [SAT_CNT_W-1:0] sat_run;

    // Counted at acceptance so output stalls never skew the frame total.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            sat_run       <= '0;
            sat_cnt_frame <= '0;
        end else if (accept) begin
            if (in_sof) begin
                sat_cnt_frame <= sat_run;
                sat_run       <= SAT_CNT_W'(code_sat);
            end else if (code_sat && (sat_run != {SAT_CNT_W{1'b1}})) begin
                sat_run <= sat_run + SAT_CNT_W'(1);
            end
        end
    end
`endif

endmodule
